// File: rtl/rl_pair_scheduler.sv
// rl_pair_scheduler
// Sequencing controller for the range-limited LJ evaluation unit. It walks the
// home cell's reference particles in groups of NUM_FILTER and, for each group,
// streams every particle of the home cell and of the 13 half-shell neighbour
// cells past the filters. It emits the per-filter pair_valid mask, the IDs, the
// phase flag and the neighbour RAM read address. Filter back-pressure stalls the
// stream. After each cell the pipeline is drained so that the accumulators see a
// clean boundary.
module rl_pair_scheduler #(
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int NUM_FILTER        = 7,
  parameter int NUM_NB_CELLS      = 14,
  parameter int NB_CELL_WIDTH     = 4,
  parameter int DRAIN_CYCLES      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [PARTICLE_ID_WIDTH:0]   home_count,
  input  logic [PARTICLE_ID_WIDTH:0]   nb_count,
  input  logic [NUM_FILTER-1:0]        back_pressure,
  input  logic                         all_buffer_empty,
  output logic                         busy,
  output logic                         done,
  output logic                         ref_load,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_base,
  output logic [NB_CELL_WIDTH-1:0]     nb_cell_sel,
  output logic [PARTICLE_ID_WIDTH-1:0] nb_rd_addr,
  output logic [NUM_FILTER-1:0]        pair_valid,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_particle_id,
  output logic [PARTICLE_ID_WIDTH-1:0] nb_particle_id,
  output logic                         phase
);

  // Counts and reference indices are compared one bit wider than an ID, so a
  // full cell (count == 2**PARTICLE_ID_WIDTH) and ref_base+k never wrap.
  localparam int CW = PARTICLE_ID_WIDTH + 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_WAIT_EMPTY,
    S_DRAIN,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t                       r_state;
  logic [CW-1:0]                r_home_count;
  logic [PARTICLE_ID_WIDTH-1:0] r_nb_idx;
  logic [DW-1:0]                r_drain_cnt;

  logic [NUM_FILTER-1:0]        w_mask;
  logic [CW-1:0]                w_next_base;
  logic                         w_last_issue;
  logic                         w_more_cells;

  // Pair mask for neighbour nb_idx against each filter's reference particle.
  // In the home cell only j > i pairs are kept, which removes self pairs and
  // the mirrored duplicates.
  always_comb begin
    logic [CW-1:0] ref_idx;
    // NOTE: defaults first, so no path through the block can infer a latch.
    ref_idx = '0;
    w_mask  = '0;
    for (int k = 0; k < NUM_FILTER; k++) begin
      ref_idx   = {1'b0, ref_base} + CW'(k);
      w_mask[k] = (ref_idx < r_home_count) &&
                  ((nb_cell_sel != '0) || ({1'b0, r_nb_idx} > ref_idx));
    end
  end

  // The neighbour RAM has one cycle of read latency, so the address is driven
  // straight from the index and the registered mask lines up with the data.
  assign nb_rd_addr   = r_nb_idx;
  assign w_last_issue = ({1'b0, r_nb_idx} == (nb_count - CW'(1)));
  assign w_next_base  = {1'b0, ref_base} + CW'(NUM_FILTER);
  assign w_more_cells = (nb_cell_sel < NB_CELL_WIDTH'(NUM_NB_CELLS - 1));

  // Control FSM; every output except nb_rd_addr is registered here.
  always_ff @(posedge clk) begin
    // NOTE: this is a control block with no memories, so every register is
    // cleared; a reset mid-run aborts it without a done pulse.
    if (!rst) begin
      r_state         <= S_IDLE;
      r_home_count    <= '0;
      r_nb_idx        <= '0;
      r_drain_cnt     <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      ref_load        <= 1'b0;
      ref_base        <= '0;
      nb_cell_sel     <= '0;
      pair_valid      <= '0;
      ref_particle_id <= '0;
      nb_particle_id  <= '0;
      phase           <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // values from the start of the cycle.
      done       <= 1'b0;
      ref_load   <= 1'b0;
      pair_valid <= '0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (home_count == '0) begin
              r_state <= S_FINISH;
            end else begin
              r_home_count <= home_count;
              ref_base     <= '0;
              nb_cell_sel  <= '0;
              phase        <= 1'b0;
              busy         <= 1'b1;
              r_state      <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          ref_load <= 1'b1;
          r_nb_idx <= '0;
          r_state  <= (nb_count == '0) ? S_WAIT_EMPTY : S_STREAM;
        end

        S_STREAM: begin
          // nb_count follows nb_cell_sel, so the count of a cell entered from
          // NEXT is only visible here. An empty cell skips straight to WAIT_EMPTY.
          if (nb_count == '0) begin
            r_state <= S_WAIT_EMPTY;
          end else if (back_pressure == '0) begin
            pair_valid      <= w_mask;
            ref_particle_id <= ref_base;
            nb_particle_id  <= r_nb_idx;
            r_nb_idx        <= r_nb_idx + PARTICLE_ID_WIDTH'(1);
            if (w_last_issue) begin
              r_state <= S_WAIT_EMPTY;
            end
          end
        end

        S_WAIT_EMPTY: begin
          if (all_buffer_empty) begin
            r_drain_cnt <= DW'(DRAIN_CYCLES - 1);
            r_state     <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state <= S_NEXT;
          end else begin
            r_drain_cnt <= r_drain_cnt - DW'(1);
          end
        end

        S_NEXT: begin
          if (w_more_cells) begin
            // The same reference group stays loaded for the next cell.
            nb_cell_sel <= nb_cell_sel + NB_CELL_WIDTH'(1);
            phase       <= 1'b1;
            r_nb_idx    <= '0;
            r_state     <= S_STREAM;
          end else if (w_next_base < r_home_count) begin
            ref_base    <= ref_base + PARTICLE_ID_WIDTH'(NUM_FILTER);
            nb_cell_sel <= '0;
            phase       <= 1'b0;
            r_state     <= S_LOAD;
          end else begin
            busy    <= 1'b0;
            r_state <= S_FINISH;
          end
        end

        S_FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rl_pair_scheduler.sv
// Testbench for rl_pair_scheduler. It runs a table of whole-cell jobs against
// hand-derived pair and load totals, a pair-list reference model, hand-written
// multi-cycle sequences, and randomized back-pressure and buffer-empty jobs.
module tb_rl_pair_scheduler;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] home_count;
  logic [7:0] nb_count;
  logic [6:0] back_pressure;
  logic       all_buffer_empty;
  logic       busy;
  logic       done;
  logic       ref_load;
  logic [6:0] ref_base;
  logic [3:0] nb_cell_sel;
  logic [6:0] nb_rd_addr;
  logic [6:0] pair_valid;
  logic [6:0] ref_particle_id;
  logic [6:0] nb_particle_id;
  logic       phase;

  rl_pair_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .home_count       (home_count),
    .nb_count         (nb_count),
    .back_pressure    (back_pressure),
    .all_buffer_empty (all_buffer_empty),
    .busy             (busy),
    .done             (done),
    .ref_load         (ref_load),
    .ref_base         (ref_base),
    .nb_cell_sel      (nb_cell_sel),
    .nb_rd_addr       (nb_rd_addr),
    .pair_valid       (pair_valid),
    .ref_particle_id  (ref_particle_id),
    .nb_particle_id   (nb_particle_id),
    .phase            (phase)
  );

  // Particle count of each cell, looked up combinationally by the cell select.
  logic [7:0] cell_cnt [0:15];
  assign nb_count = cell_cnt[nb_cell_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected pair stream {cell, nb id, ref id, mask, phase} and ref_base per load.
  logic [31:0] exp_q [$];
  int          exp_load_q [$];
  logic        mon_en = 1'b0;
  logic [6:0]  bp_q = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic set_cells(input int cnt);
    for (int c = 0; c < 16; c++) cell_cnt[c] = (c < 14) ? 8'(cnt) : 8'd0;
  endtask

  // Reference model: the set of pairs (i, j) that must be evaluated, walked in
  // the order groups -> cells -> neighbour index. A slot appears only if at
  // least one filter of the group owns a real pair there.
  task automatic build_model(input int home);
    logic [6:0] m;
    exp_q.delete();
    exp_load_q.delete();
    for (int b = 0; b < home; b += 7) begin
      exp_load_q.push_back(b);
      for (int c = 0; c < 14; c++) begin
        for (int j = 0; j < int'(cell_cnt[c]); j++) begin
          m = '0;
          for (int k = 0; k < 7; k++) begin
            if ((b + k) < home && (c != 0 || j > (b + k))) m[k] = 1'b1;
          end
          if (m != '0) exp_q.push_back(32'({c[3:0], j[6:0], b[6:0], m, (c != 0)}));
        end
      end
    end
  endtask

  // Back-pressure captured at each active edge; the following cycle must not
  // present a pair.
  always @(posedge clk) bp_q <= back_pressure;

  // Stream monitor: compares every presented pair and every reference load
  // against the model.
  always @(negedge clk) begin
    logic [31:0] got;
    if (rst && bp_q != '0) check("stall_slot_empty", 32'(pair_valid), 32'd0);
    if (mon_en && rst) begin
      if (pair_valid != '0) begin
        got = 32'({nb_cell_sel, nb_particle_id, ref_particle_id, pair_valid, phase});
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pair_extra: got 0x%0h, expected no pair", got);
        end else begin
          check("pair", got, exp_q.pop_front());
        end
      end
      if (ref_load) begin
        if (exp_load_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL ref_load_extra: got base %0d, expected no load", ref_base);
        end else begin
          check("ref_load_base", 32'(ref_base), exp_load_q.pop_front());
        end
      end
    end
  end

  // One complete job with optional random back-pressure and buffer-not-empty.
  task automatic run_job(input int home, input int bp_pct, input int abe_pct,
                         output int loads, output int bits);
    int dones;
    int cyc;
    build_model(home);
    loads = 0;
    bits  = 0;
    dones = 0;
    mon_en = 1'b1;
    home_count = 8'(home);
    back_pressure = '0;
    all_buffer_empty = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (dones == 0 && cyc < 30000) begin
      back_pressure = (int'($urandom_range(99)) < bp_pct) ? 7'($urandom_range(127, 1)) : 7'd0;
      all_buffer_empty = (int'($urandom_range(99)) >= abe_pct);
      tick();
      cyc++;
      if (ref_load) loads++;
      bits += $countones(pair_valid);
      if (done) dones++;
    end
    back_pressure = '0;
    all_buffer_empty = 1'b1;
    check("job_done_seen", 32'(dones), 32'd1);
    tick();
    check("job_busy_after_done", 32'(busy), 32'd0);
    mon_en = 1'b0;
    check("job_pairs_left", 32'(exp_q.size()), 32'd0);
    check("job_loads_left", 32'(exp_load_q.size()), 32'd0);
    if (dones == 0) do_reset();
  endtask

  typedef struct {
    int home;
    int nb;
    int exp_loads;
    int exp_bits;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int loads;
    int bits;
    int guard;
    int cnt;
    logic ok;

    // Totals by hand: home-cell pairs need j > i, other cells pair every ref.
    vecs[0] = '{home: 0,   nb: 3, exp_loads: 0,  exp_bits: 0};
    vecs[1] = '{home: 3,   nb: 2, exp_loads: 1,  exp_bits: 79};
    vecs[2] = '{home: 10,  nb: 2, exp_loads: 2,  exp_bits: 261};
    vecs[3] = '{home: 1,   nb: 5, exp_loads: 1,  exp_bits: 69};
    vecs[4] = '{home: 7,   nb: 0, exp_loads: 1,  exp_bits: 0};
    vecs[5] = '{home: 8,   nb: 8, exp_loads: 2,  exp_bits: 860};
    vecs[6] = '{home: 128, nb: 1, exp_loads: 19, exp_bits: 1664};

    rst = 1'b0;
    start = 1'b0;
    home_count = '0;
    back_pressure = '0;
    all_buffer_empty = 1'b1;
    set_cells(0);
    do_reset();

    // Reset state.
    check("reset_outputs",
          32'({busy, done, ref_load, ref_base, nb_cell_sel, pair_valid,
               ref_particle_id, nb_particle_id, phase, nb_rd_addr}), 32'd0);

    // Empty home cell: done two cycles after the start cycle, no load, no pair.
    home_count = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_done_early", 32'({done, ref_load, pair_valid}), 32'd0);
    tick();
    check("empty_done_pulse", 32'({done, ref_load, pair_valid}), 32'h100);
    tick();
    check("empty_done_cleared", 32'(done), 32'd0);

    // Table of whole jobs with uniform cell counts.
    for (int v = 0; v < 7; v++) begin
      set_cells(vecs[v].nb);
      run_job(vecs[v].home, 0, 0, loads, bits);
      check($sformatf("tbl%0d_loads", v), 32'(loads), 32'(vecs[v].exp_loads));
      check($sformatf("tbl%0d_pair_bits", v), 32'(bits), 32'(vecs[v].exp_bits));
    end

    // Back-pressure freeze in group 1, cell 1, then abort by reset.
    set_cells(10);
    home_count = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(ref_base == 7'd7 && nb_cell_sel == 4'd1 && nb_rd_addr == 7'd4) && guard < 5000) begin
      tick();
      guard++;
    end
    check("bp_reach_grp1_cell1", 32'(guard < 5000), 32'd1);
    back_pressure = 7'b0000100;
    for (int s = 0; s < 5; s++) begin
      tick();
      check($sformatf("bp_hold_addr%0d", s), 32'(nb_rd_addr), 32'd4);
      check($sformatf("bp_hold_valid%0d", s), 32'(pair_valid), 32'd0);
    end
    back_pressure = '0;
    tick();
    check("bp_resume_pair",
          32'({pair_valid, ref_particle_id, nb_particle_id, phase}),
          32'({7'b0000111, 7'd7, 7'd4, 1'b1}));
    check("bp_resume_addr", 32'(nb_rd_addr), 32'd5);

    rst = 1'b0;
    tick();
    check("abort_outputs",
          32'({busy, done, ref_load, ref_base, nb_cell_sel, pair_valid,
               ref_particle_id, nb_particle_id, phase, nb_rd_addr}), 32'd0);
    rst = 1'b1;
    cnt = 0;
    ok = 1'b1;
    for (int s = 0; s < 40; s++) begin
      tick();
      if (done) cnt++;
      if (busy) ok = 1'b0;
    end
    check("abort_no_done", 32'(cnt), 32'd0);
    check("abort_stays_idle", 32'(ok), 32'd1);
    home_count = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("restart_load_base0", 32'({ref_load, ref_base}), 32'({1'b1, 7'd0}));
    do_reset();

    // Buffers held non-empty for 20 cycles after the last home-cell pair.
    set_cells(2);
    home_count = 8'd3;
    all_buffer_empty = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (pair_valid == '0 && guard < 100) begin
      tick();
      guard++;
    end
    check("abe_last_home_pair",
          32'({pair_valid, nb_particle_id}), 32'({7'b0000001, 7'd1}));
    ok = 1'b1;
    for (int s = 0; s < 20; s++) begin
      tick();
      if (nb_cell_sel != 4'd0 || !busy || pair_valid != '0) ok = 1'b0;
    end
    check("abe_wait_holds", 32'(ok), 32'd1);
    all_buffer_empty = 1'b1;
    cnt = 0;
    while (nb_cell_sel != 4'd1 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("abe_cycles_to_next_cell", 32'(cnt), 32'd34);
    tick();
    check("abe_first_cell1_pair",
          32'({pair_valid, nb_particle_id, phase}), 32'({7'b0000111, 7'd0, 1'b1}));
    do_reset();

    // Randomized jobs against the reference model.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 16; c++) cell_cnt[c] = (c < 14) ? 8'($urandom_range(6)) : 8'd0;
      run_job(int'($urandom_range(20)), 25, 30, loads, bits);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rl_pair_scheduler.md
Name: rl_pair_scheduler

Overview:
- Sequencing controller for the range-limited LJ evaluation unit (7-filter pipeline plus per-filter partial force accumulators).
- Walks the home cell's reference particles in groups of NUM_FILTER.
- Streams every particle of each half-shell cell (home cell first) against the current group.
- Generates the per-filter pair_valid mask, IDs, phase and neighbor-memory read address.
- Honours filter back-pressure and drains the pipeline before moving to the next group.

Parameters:
- PARTICLE_ID_WIDTH, 7: particle index width within a cell.
- NUM_FILTER, 7: reference particles per group, equal to the number of filters.
- NUM_NB_CELLS, 14: cells visited per group; cell 0 is the home cell, cells 1..13 are the half-shell neighbours.
- NB_CELL_WIDTH, 4: width of the cell select.
- DRAIN_CYCLES, 32: cycles waited after all buffers are empty, covering force pipeline plus accumulator latency.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle start pulse; ignored while busy.
- home_count  in  PARTICLE_ID_WIDTH+1  number of particles in the home cell; sampled on start.
- nb_count  in  PARTICLE_ID_WIDTH+1  particle count of the cell selected by nb_cell_sel; valid combinationally.
- back_pressure  in  NUM_FILTER  per-filter back-pressure from the evaluation unit.
- all_buffer_empty  in  1  all filter buffers are empty.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the whole home cell has been processed.
- ref_load  out  1  one-cycle pulse; the reference buffer latches positions ref_base..ref_base+NUM_FILTER-1.
- ref_base  out  PARTICLE_ID_WIDTH  first reference index of the current group.
- nb_cell_sel  out  NB_CELL_WIDTH  current neighbour cell.
- nb_rd_addr  out  PARTICLE_ID_WIDTH  combinational, equals nb_idx; neighbour RAM has 1-cycle read latency.
- pair_valid  out  NUM_FILTER  registered; aligned with the RAM data.
- ref_particle_id  out  PARTICLE_ID_WIDTH  registered; equals ref_base.
- nb_particle_id  out  PARTICLE_ID_WIDTH  registered.
- phase  out  1  0 while nb_cell_sel==0, otherwise 1.

Behaviour:
- Reset (rst==0 at clk edge):
  - State IDLE.
  - Outputs busy, done, ref_load, ref_base, nb_cell_sel, pair_valid, ref_particle_id, nb_particle_id and phase all go to 0.
  - Internal nb_idx and drain counter go to 0.
  - Reset mid-operation aborts immediately; no done pulse is generated.
- FSM states: IDLE, LOAD, STREAM, WAIT_EMPTY, DRAIN, NEXT, FINISH.
- IDLE:
  - On start with home_count==0, go to FINISH.
  - On start otherwise, latch home_count, set ref_base=0 and nb_cell_sel=0, then go to LOAD.
- LOAD:
  - Assert ref_load for exactly 1 cycle.
  - Set nb_idx=0.
  - Go to STREAM, or to WAIT_EMPTY if nb_count==0.
- STREAM, each cycle:
  - If back_pressure!=0, stall: nb_idx holds and the registered pair_valid is 0 next cycle.
  - Otherwise issue one pair:
    - pair_valid[k] <= (ref_base+k < home_count) && (nb_cell_sel!=0 || nb_idx > ref_base+k).
    - The home-cell term keeps only j>i pairs, so there is no self pair and no duplicate.
    - nb_particle_id <= nb_idx; ref_particle_id <= ref_base.
    - nb_idx increments.
  - When the issued index equals nb_count-1, go to WAIT_EMPTY.
  - An all-zero mask still consumes the slot and advances nb_idx.
- pair_valid is 0 in every cycle it is not explicitly issued.
- WAIT_EMPTY: wait for all_buffer_empty==1, then load the drain counter with DRAIN_CYCLES-1 and go to DRAIN.
- DRAIN: decrement the counter; at 0, go to NEXT.
- NEXT, evaluated in order:
  - If nb_cell_sel < NUM_NB_CELLS-1: increment nb_cell_sel, set nb_idx=0, then go to STREAM, or WAIT_EMPTY if the new nb_count==0. The reference group is kept, so there is no reload.
  - Else if ref_base+NUM_FILTER < home_count: ref_base += NUM_FILTER, nb_cell_sel=0, go to LOAD.
  - Else go to FINISH.
- Drain happens once per cell, so the accumulator sees a clean boundary at each phase change.
- FINISH: done=1 for 1 cycle, busy=0, return to IDLE.
- busy is 1 in every state except IDLE and FINISH.
- Widths and arithmetic:
  - ref_base+k and the comparisons are computed at PARTICLE_ID_WIDTH+1 bits, so there is no wrap.
  - home_count=128 with width 7 is legal.
  - The last group may be partial; its upper mask bits are 0.
- start asserted while busy has no effect.
- start in the same cycle as FINISH is ignored.

Test Plan:
- home_count=0, start → done pulses 2 cycles later; no ref_load; pair_valid stays 0.
- home_count=3, all nb_count=2, no back-pressure, all_buffer_empty=1 →
  - Home cell: nb0 mask 0, nb1 mask 0b0000001, nb2 not issued (count 2).
  - Cells 1..13: mask 0b0000111 for both nb.
  - Phase flips to 1 at cell 1.
  - 13 DRAIN windows of 32 cycles between cells, then done.
- home_count=10 → two ref_load pulses, ref_base 0 then 7; second group's masks are limited to 0b0000111.
- back_pressure=0b0000100 held for 5 cycles mid-stream → nb_idx frozen; pair_valid 0 for 5 cycles; no index skipped or repeated.
- all_buffer_empty held 0 for 20 cycles after the last pair → FSM stays in WAIT_EMPTY, then 32 drain cycles, then the next cell.
- rst low during STREAM → all outputs 0 the next cycle, no done pulse; a new start runs from ref_base=0.
